// File: rtl/mips_ex_pkg.sv
// Shared definitions for the MIPS execute stage: ALU operation codes,
// mul/div sequencer states and the pass-through control bundle.
package mips_ex_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_DIVU  = 4'd9;
  localparam logic [3:0] ALU_NOR   = 4'd12;

  localparam int MD_CYC_DEF = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic branch;
    logic mem_write;
    logic mem_read;
    logic jump;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply (shift-add, low word) and restoring divide
// (quotient), one bit per cycle. Only built when MIPS_EX_MULDIV_EN is defined.
//   state   | meaning
//   MD_IDLE | waiting for i_start
//   MD_BUSY | iterating, r_cnt = 0..MD_CYC-1
//   MD_DONE | o_result valid for one (unheld) cycle
module ex_muldiv_unit
  import mips_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MD_CYC = MD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_abort,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam int CW = (MD_CYC > 1) ? $clog2(MD_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_CYC - 1);

  md_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_op;
  logic [DATA_W-1:0] r_a, r_b, r_acc;
  logic [DATA_W:0]   w_rem_sh, w_diff;
  logic [DATA_W-1:0] w_mul_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = MD_IDLE;
    end else if (!i_hold) begin
      case (r_state)
        MD_IDLE: if (i_start) w_state_nxt = MD_BUSY;
        MD_BUSY: if (r_cnt == LAST) w_state_nxt = MD_DONE;
        MD_DONE: w_state_nxt = MD_IDLE;
        default: w_state_nxt = MD_IDLE;
      endcase
    end
  end

  // Divide: r_acc is the partial remainder, r_a shifts the dividend out and the quotient in.
  // A zero divisor never borrows, so the quotient naturally saturates to all ones.
  assign w_rem_sh  = {r_acc, r_a[DATA_W-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_mul_sum = r_acc + (r_b[0] ? r_a : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_op  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (!i_hold && !i_abort) begin
      if (r_state == MD_IDLE && i_start) begin
        r_cnt <= '0;
        r_op  <= i_op;
        r_a   <= i_a;
        r_b   <= i_b;
        r_acc <= '0;
      end else if (r_state == MD_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_op) begin
          if (!w_diff[DATA_W]) begin
            r_acc <= w_diff[DATA_W-1:0];
            r_a   <= {r_a[DATA_W-2:0], 1'b1};
          end else begin
            r_acc <= w_rem_sh[DATA_W-1:0];
            r_a   <= {r_a[DATA_W-2:0], 1'b0};
          end
        end else begin
          r_acc <= w_mul_sum;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
        end
      end
    end
  end

  assign o_busy   = (r_state != MD_IDLE);
  assign o_done   = (r_state == MD_DONE);
  assign o_result = r_op ? r_a : r_acc;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage with the EX/MEM pipeline register. Define
// MIPS_EX_MULDIV_EN to build the multi-cycle MULTU/DIVU unit; otherwise they return 0.
module ex_stage
  import mips_ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MD_CYC = MD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] IDtoEX_ReadData1,
  input  logic [DATA_W-1:0] IDtoEX_ReadData2,
  input  logic [DATA_W-1:0] IDtoEX_SignExtImm,
  input  logic [DATA_W-1:0] IDtoEX_PC_plus4,
  input  logic [25:0]       IDtoEX_JumpTarget,
  input  logic [4:0]        IDtoEX_Rt,
  input  logic [4:0]        IDtoEX_Rd,
  input  logic              RegDst,
  input  logic              ALUSrc,
  input  logic [3:0]        ALUOp,
  input  logic              Branch,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Jump,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  output logic [DATA_W-1:0] EXtoMEM_ALUresult,
  output logic              EXtoMEM_zero,
  output logic [4:0]        EXtoMEM_Rt,
  output logic [DATA_W-1:0] EXtoMEM_WriteData,
  output logic [DATA_W-1:0] EXtoMEM_Branch_Addr,
  output logic [DATA_W-1:0] EXtoMEM_Jump_address,
  output logic [4:0]        EXtoMEM_RegDest,
  output logic              EXtoMEM_valid,
  output logic              EXtoMEM_Branch,
  output logic              EXtoMEM_MemWrite,
  output logic              EXtoMEM_MemRead,
  output logic              EXtoMEM_Jump,
  output logic              EXtoMEM_RegWrite,
  output logic              EXtoMEM_MemtoReg,
  output logic              ex_busy
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [4:0]        rt;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] branch_addr;
    logic [DATA_W-1:0] jump_addr;
    logic [4:0]        reg_dest;
    logic              valid;
    ctrl_t             ctrl;
  } exmem_t;

  exmem_t            r_exmem, w_cur;
  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_opb, w_alu;
  logic              w_slt;

  assign w_opb  = ALUSrc ? IDtoEX_SignExtImm : IDtoEX_ReadData2;
  assign w_slt  = $signed(IDtoEX_ReadData1) < $signed(w_opb);
  assign w_ctrl = {Branch, MemWrite, MemRead, Jump, RegWrite, MemtoReg};

  always_comb begin
    w_alu = '0;
    case (ALUOp)
      ALU_AND: w_alu = IDtoEX_ReadData1 & w_opb;
      ALU_OR:  w_alu = IDtoEX_ReadData1 | w_opb;
      ALU_ADD: w_alu = IDtoEX_ReadData1 + w_opb;
      ALU_SUB: w_alu = IDtoEX_ReadData1 - w_opb;
      ALU_SLT: w_alu = {{(DATA_W-1){1'b0}}, w_slt};
      ALU_NOR: w_alu = ~(IDtoEX_ReadData1 | w_opb);
      default: w_alu = '0;
    endcase
  end

  // A bubble from ID carries no control side effects into MEM.
  always_comb begin
    w_cur             = '0;
    w_cur.alu_result  = w_alu;
    w_cur.zero        = (w_alu == '0);
    w_cur.rt          = IDtoEX_Rt;
    w_cur.write_data  = IDtoEX_ReadData2;
    w_cur.branch_addr = IDtoEX_PC_plus4 + {IDtoEX_SignExtImm[DATA_W-3:0], 2'b00};
    w_cur.jump_addr   = {IDtoEX_PC_plus4[DATA_W-1:28], IDtoEX_JumpTarget, 2'b00};
    w_cur.reg_dest    = RegDst ? IDtoEX_Rd : IDtoEX_Rt;
    w_cur.valid       = id_valid;
    w_cur.ctrl        = id_valid ? w_ctrl : '0;
  end

`ifdef MIPS_EX_MULDIV_EN
  exmem_t            r_md_lat, w_md_out;
  logic              w_is_md, w_md_start, w_md_busy, w_md_done;
  logic [DATA_W-1:0] w_md_result;

  assign w_is_md    = (ALUOp == ALU_MULTU) || (ALUOp == ALU_DIVU);
  assign w_md_start = id_valid && w_is_md && !flush && !mem_stall && !w_md_busy;

  ex_muldiv_unit #(
    .DATA_W (DATA_W),
    .MD_CYC (MD_CYC)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_md_start),
    .i_op     (ALUOp == ALU_DIVU),
    .i_a      (IDtoEX_ReadData1),
    .i_b      (w_opb),
    .i_abort  (flush),
    .i_hold   (mem_stall),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  // Upstream moves on after accept, so everything but the result is captured here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_md_lat <= '0;
    else if (w_md_start) r_md_lat <= w_cur;
  end

  always_comb begin
    w_md_out            = r_md_lat;
    w_md_out.alu_result = w_md_result;
    w_md_out.zero       = (w_md_result == '0);
    w_md_out.valid      = 1'b1;
  end

  assign ex_busy = w_md_busy;
`else
  assign ex_busy = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exmem <= '0;
    end else if (flush) begin
      r_exmem.valid <= 1'b0;
      r_exmem.ctrl  <= '0;
    end else if (!mem_stall) begin
`ifdef MIPS_EX_MULDIV_EN
      if (w_md_done) begin
        r_exmem <= w_md_out;
      end else if (w_md_start || w_md_busy) begin
        r_exmem.valid <= 1'b0;
        r_exmem.ctrl  <= '0;
      end else begin
        r_exmem <= w_cur;
      end
`else
      r_exmem <= w_cur;
`endif
    end
  end

  assign EXtoMEM_ALUresult    = r_exmem.alu_result;
  assign EXtoMEM_zero         = r_exmem.zero;
  assign EXtoMEM_Rt           = r_exmem.rt;
  assign EXtoMEM_WriteData    = r_exmem.write_data;
  assign EXtoMEM_Branch_Addr  = r_exmem.branch_addr;
  assign EXtoMEM_Jump_address = r_exmem.jump_addr;
  assign EXtoMEM_RegDest      = r_exmem.reg_dest;
  assign EXtoMEM_valid        = r_exmem.valid;
  assign EXtoMEM_Branch       = r_exmem.ctrl.branch;
  assign EXtoMEM_MemWrite     = r_exmem.ctrl.mem_write;
  assign EXtoMEM_MemRead      = r_exmem.ctrl.mem_read;
  assign EXtoMEM_Jump         = r_exmem.ctrl.jump;
  assign EXtoMEM_RegWrite     = r_exmem.ctrl.reg_write;
  assign EXtoMEM_MemtoReg     = r_exmem.ctrl.mem_to_reg;

endmodule
